slow_tick_monitor: RTL and testbench

// Consumer side of the slow divided-clock outputs (1 Hz / 0.1 Hz class) in the pseudo-terminal design.
// - Samples the slow clock as data in the 100 MHz domain through a synchronizer.
// - Emits single-cycle rise/fall strobes and counts rising edges.
// - Measures each half period and checks it against the expected value.
// - Reports lock, early-edge and late-edge (stall) status to the terminal status logic.

---
 rtl/slow_tick_monitor_pkg.sv | 21 ++
 rtl/slow_tick_monitor_sync_edge.sv | 32 +++
 rtl/slow_tick_monitor.sv | 149 ++++++++++++++
 tb/tb_slow_tick_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/slow_tick_monitor_pkg.sv
// Shared definitions for the slow divided-clock monitor: FSM state codes and
// the 100 MHz half-period constants shared with the divider blocks.
package slow_tick_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } mon_state_t;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned HALF_PERIOD_0P1HZ = CLK_HZ * 5;
    localparam int unsigned HALF_PERIOD_1HZ   = CLK_HZ / 2;
    localparam int unsigned DEF_TOL           = 1000;
    localparam int unsigned DEF_CNT_W         = 32;
    localparam int unsigned TICK_CNT_W        = 16;

    // In-tolerance half periods needed before lock is reported
    localparam logic [1:0]  GOOD_TARGET       = 2'd2;

endpackage

// File: rtl/slow_tick_monitor_sync_edge.sv
// Synchronizer for an asynchronous slow clock plus edge detection on the
// synchronized level.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer always runs so a later enable never sees a stale edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign lvl    = sync_q[STAGES-1];
    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/slow_tick_monitor.sv
// Slow-clock consumer: edge strobes, rising-edge count, half-period
// measurement against an expected value, and lock/early/late status.
module slow_tick_monitor
    import slow_tick_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EXP_HALF_PERIOD = HALF_PERIOD_0P1HZ,
    parameter int unsigned TOL             = DEF_TOL,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slow_clk_in,
    input  logic                  enable,
    input  logic                  clear_err,
    output logic                  tick_rise,
    output logic                  tick_fall,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0]      half_period_meas,
    output logic                  locked,
    output logic                  err_early,
    output logic                  err_late
);

    localparam logic [CNT_W-1:0] EARLY_LIM = CNT_W'(EXP_HALF_PERIOD - TOL);
    localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(EXP_HALF_PERIOD + TOL);
    localparam logic [CNT_W-1:0] LATE_LIM  = CNT_W'(EXP_HALF_PERIOD + TOL + 1);

    logic slow_lvl;
    logic slow_rise_c;
    logic slow_fall_c;
    logic edge_c;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (slow_clk_in),
        .lvl    (slow_lvl),
        .rise_c (slow_rise_c),
        .fall_c (slow_fall_c)
    );

    assign edge_c = slow_rise_c | slow_fall_c;

    mon_state_t            state,          state_nxt;
    logic [CNT_W-1:0]      hp_cnt,         hp_cnt_nxt;
    logic [1:0]            good_cnt,       good_cnt_nxt;
    logic [CNT_W-1:0]      meas_nxt;
    logic [TICK_CNT_W-1:0] tick_count_nxt;
    logic                  tick_rise_nxt;
    logic                  tick_fall_nxt;
    logic                  locked_nxt;
    logic                  err_early_nxt;
    logic                  err_late_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            hp_cnt           <= '0;
            good_cnt         <= '0;
            half_period_meas <= '0;
            tick_count       <= '0;
            tick_rise        <= 1'b0;
            tick_fall        <= 1'b0;
            locked           <= 1'b0;
            err_early        <= 1'b0;
            err_late         <= 1'b0;
        end else begin
            state            <= state_nxt;
            hp_cnt           <= hp_cnt_nxt;
            good_cnt         <= good_cnt_nxt;
            half_period_meas <= meas_nxt;
            tick_count       <= tick_count_nxt;
            tick_rise        <= tick_rise_nxt;
            tick_fall        <= tick_fall_nxt;
            locked           <= locked_nxt;
            err_early        <= err_early_nxt;
            err_late         <= err_late_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hp_cnt_nxt     = hp_cnt;
        good_cnt_nxt   = good_cnt;
        meas_nxt       = half_period_meas;
        locked_nxt     = locked;
        // Clear first so a same-cycle set below wins
        err_early_nxt  = clear_err ? 1'b0 : err_early;
        err_late_nxt   = clear_err ? 1'b0 : err_late;
        tick_rise_nxt  = enable & edge_c & slow_lvl;
        tick_fall_nxt  = enable & edge_c & ~slow_lvl;
        tick_count_nxt = tick_count;

        if (tick_rise_nxt) begin
            tick_count_nxt = tick_count + TICK_CNT_W'(1);
        end

        if (!enable) begin
            state_nxt    = ST_IDLE;
            locked_nxt   = 1'b0;
            good_cnt_nxt = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (edge_c) begin
                        hp_cnt_nxt = CNT_W'(1);
                        state_nxt  = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (edge_c) begin
                        meas_nxt   = hp_cnt;
                        hp_cnt_nxt = CNT_W'(1);
                        if (hp_cnt < EARLY_LIM) begin
                            err_early_nxt = 1'b1;
                            locked_nxt    = 1'b0;
                            good_cnt_nxt  = 2'd0;
                        end else if (hp_cnt <= HI_LIM) begin
                            good_cnt_nxt = (good_cnt == GOOD_TARGET) ? good_cnt
                                                                     : good_cnt + 2'd1;
                            locked_nxt   = (good_cnt_nxt == GOOD_TARGET);
                        end else begin
                            locked_nxt   = 1'b0;
                            good_cnt_nxt = 2'd0;
                        end
                    end else if (hp_cnt >= LATE_LIM) begin
                        // Stall: hold hp_cnt and re-acquire without measuring
                        err_late_nxt = 1'b1;
                        locked_nxt   = 1'b0;
                        good_cnt_nxt = 2'd0;
                        state_nxt    = ST_ACQUIRE;
                    end else begin
                        hp_cnt_nxt = hp_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_tick_monitor.sv
// Directed bench for slow_tick_monitor with a short expected half period
// (EXP=10, TOL=2, two synchronizer stages).
module tb_slow_tick_monitor;

    logic        clk;
    logic        rst;
    logic        slow_clk_in;
    logic        enable;
    logic        clear_err;
    logic        tick_rise;
    logic        tick_fall;
    logic [15:0] tick_count;
    logic [7:0]  half_period_meas;
    logic        locked;
    logic        err_early;
    logic        err_late;

    int n_cmp;
    int n_err;

    slow_tick_monitor #(
        .SYNC_STAGES     (2),
        .EXP_HALF_PERIOD (10),
        .TOL             (2),
        .CNT_W           (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .slow_clk_in      (slow_clk_in),
        .enable           (enable),
        .clear_err        (clear_err),
        .tick_rise        (tick_rise),
        .tick_fall        (tick_fall),
        .tick_count       (tick_count),
        .half_period_meas (half_period_meas),
        .locked           (locked),
        .err_early        (err_early),
        .err_late         (err_late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tick_rise"}, 32'(tick_rise), 32'd0);
        check({tag, ".tick_fall"}, 32'(tick_fall), 32'd0);
        check({tag, ".tick_count"}, 32'(tick_count), 32'd0);
        check({tag, ".meas"}, 32'(half_period_meas), 32'd0);
        check({tag, ".locked"}, 32'(locked), 32'd0);
        check({tag, ".err_early"}, 32'(err_early), 32'd0);
        check({tag, ".err_late"}, 32'(err_late), 32'd0);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        slow_clk_in = 1'b0;
        clear_err   = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst    = 1'b0;
        enable = 1'b1;
        tick(5);

        // 1: 10-clk halves; strobe 3 clk after change, lock on third edge
        slow_clk_in = 1'b1;
        tick(2);
        check("t1.rise_not_yet", 32'(tick_rise), 32'd0);
        tick(1);
        check("t1.rise_at_3", 32'(tick_rise), 32'd1);
        check("t1.count1", 32'(tick_count), 32'd1);
        check("t1.no_meas_first", 32'(half_period_meas), 32'd0);
        tick(1);
        check("t1.rise_single", 32'(tick_rise), 32'd0);
        tick(6);
        slow_clk_in = 1'b0;
        tick(3);
        check("t1.fall", 32'(tick_fall), 32'd1);
        check("t1.meas10a", 32'(half_period_meas), 32'd10);
        check("t1.not_locked_2nd", 32'(locked), 32'd0);
        tick(7);
        slow_clk_in = 1'b1;
        tick(3);
        check("t1.meas10b", 32'(half_period_meas), 32'd10);
        check("t1.locked_3rd", 32'(locked), 32'd1);
        check("t1.count2", 32'(tick_count), 32'd2);
        check("t1.no_early", 32'(err_early), 32'd0);
        check("t1.no_late", 32'(err_late), 32'd0);
        tick(7);

        // 2: one 6-clk half -> early error, relock after two good halves
        slow_clk_in = 1'b0;
        tick(6);
        slow_clk_in = 1'b1;
        tick(3);
        check("t2.err_early", 32'(err_early), 32'd1);
        check("t2.unlocked", 32'(locked), 32'd0);
        check("t2.meas6", 32'(half_period_meas), 32'd6);
        tick(7);
        slow_clk_in = 1'b0;
        tick(3);
        check("t2.one_good_unlocked", 32'(locked), 32'd0);
        check("t2.meas10", 32'(half_period_meas), 32'd10);
        tick(7);
        slow_clk_in = 1'b1;
        tick(3);
        check("t2.relocked", 32'(locked), 32'd1);
        check("t2.early_sticky", 32'(err_early), 32'd1);
        tick(7);

        // 3: stall -> late error exactly 13 clk after the last synced edge
        tick(5);
        check("t3.late_not_yet", 32'(err_late), 32'd0);
        check("t3.still_locked", 32'(locked), 32'd1);
        tick(1);
        check("t3.late_at_13", 32'(err_late), 32'd1);
        check("t3.unlocked", 32'(locked), 32'd0);
        slow_clk_in = 1'b0;
        tick(3);
        check("t3.fall_seen", 32'(tick_fall), 32'd1);
        check("t3.no_meas_reacq", 32'(half_period_meas), 32'd10);
        check("t3.early_kept", 32'(err_early), 32'd1);

        // 4: clear in the same cycle late sets -> late stays, early clears
        tick(12);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t4.set_wins", 32'(err_late), 32'd1);
        check("t4.early_cleared", 32'(err_early), 32'd0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t4.late_cleared", 32'(err_late), 32'd0);
        check("t4.early_still0", 32'(err_early), 32'd0);

        // 5: tick_count wrap from 0xFFFF, then disable mid-TRACK
        force dut.tick_count = 16'hFFFF;
        #1;
        release dut.tick_count;
        slow_clk_in = 1'b1;
        tick(3);
        check("t5.wrap_rise", 32'(tick_rise), 32'd1);
        check("t5.wrap_count", 32'(tick_count), 32'd0);
        tick(7);
        slow_clk_in = 1'b0;
        tick(10);
        slow_clk_in = 1'b1;
        tick(3);
        check("t5.locked", 32'(locked), 32'd1);
        check("t5.count1", 32'(tick_count), 32'd1);
        tick(7);
        enable = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 2 || i == 12) slow_clk_in = ~slow_clk_in;
            tick(1);
            check("t5.dis_no_rise", 32'(tick_rise), 32'd0);
            check("t5.dis_no_fall", 32'(tick_fall), 32'd0);
        end
        check("t5.dis_unlocked", 32'(locked), 32'd0);
        check("t5.dis_count_held", 32'(tick_count), 32'd1);
        check("t5.dis_meas_held", 32'(half_period_meas), 32'd10);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t5.reen_no_rise", 32'(tick_rise), 32'd0);
            check("t5.reen_no_fall", 32'(tick_fall), 32'd0);
        end

        // 6: async reset while locked and mid-count
        slow_clk_in = 1'b0;
        tick(10);
        slow_clk_in = 1'b1;
        tick(10);
        slow_clk_in = 1'b0;
        tick(3);
        check("t6.locked", 32'(locked), 32'd1);
        check("t6.count2", 32'(tick_count), 32'd2);
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6.async");
        tick(2);
        rst = 1'b0;
        tick(3);
        slow_clk_in = 1'b1;
        tick(3);
        check("t6.first_rise", 32'(tick_rise), 32'd1);
        check("t6.first_count", 32'(tick_count), 32'd1);
        check("t6.first_no_meas", 32'(half_period_meas), 32'd0);
        check("t6.first_unlocked", 32'(locked), 32'd0);
        tick(7);
        slow_clk_in = 1'b0;
        tick(3);
        check("t6.second_fall", 32'(tick_fall), 32'd1);
        check("t6.second_meas", 32'(half_period_meas), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
